// File: rtl/cic_decimator.sv
// N-stage CIC decimator: integrators run on clk_en, combs run on the decimated strobe.
// Output is the MSB-truncated comb result with a single-cycle valid pulse.
module cic_decimator #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned N         = 3,
  parameter int unsigned R         = 8,
  parameter int unsigned M         = 1,
  parameter int unsigned GROWTH    = N * $clog2(R * M),
  parameter int unsigned ACC_WIDTH = IN_WIDTH + GROWTH,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data
);

  localparam int unsigned CntWidth = (R > 1) ? $clog2(R) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(R - 1);

  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] integ_q [N];
  logic [CntWidth-1:0]         cnt_q;
  logic signed [ACC_WIDTH-1:0] dec_q;
  logic                        dec_stb_q;
  logic signed [ACC_WIDTH-1:0] comb_q [N];
  logic [N-1:0]                comb_stb_q;
  logic signed [ACC_WIDTH-1:0] dly_q [N][M];
  logic signed [ACC_WIDTH-1:0] comb_in [N];
  logic [N-1:0]                comb_stb_in;

  // Size cast of a signed operand sign-extends.
  assign in_ext = ACC_WIDTH'(in_data);

  // Integrators wrap freely; the combs cancel the overflow exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < N; k++) integ_q[k] <= '0;
      cnt_q     <= '0;
      dec_q     <= '0;
      dec_stb_q <= 1'b0;
    end else begin
      dec_stb_q <= clk_en && (cnt_q == CntMax);
      if (clk_en) begin
        integ_q[0] <= integ_q[0] + in_ext;
        for (int unsigned k = 1; k < N; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
        cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        if (cnt_q == CntMax) dec_q <= integ_q[N-1];
      end
    end
  end

  always_comb begin
    comb_in[0]     = dec_q;
    comb_stb_in[0] = dec_stb_q;
    for (int unsigned k = 1; k < N; k++) begin
      comb_in[k]     = comb_q[k-1];
      comb_stb_in[k] = comb_stb_q[k-1];
    end
  end

  // Each comb stage advances only on its own incoming strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      comb_stb_q <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        comb_q[k] <= '0;
        for (int unsigned d = 0; d < M; d++) dly_q[k][d] <= '0;
      end
    end else begin
      comb_stb_q <= comb_stb_in;
      for (int unsigned k = 0; k < N; k++) begin
        if (comb_stb_in[k]) begin
          comb_q[k]   <= comb_in[k] - dly_q[k][M-1];
          dly_q[k][0] <= comb_in[k];
          for (int unsigned d = 1; d < M; d++) dly_q[k][d] <= dly_q[k][d-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= comb_stb_q[N-1];
      if (comb_stb_q[N-1]) out_data <= comb_q[N-1][ACC_WIDTH-1 -: OUT_WIDTH];
    end
  end

endmodule
